sargantana_icache_flush_ctrl: RTL and testbench

//  Sequences invalidation of the icache valid array. Serves two requesters:
//   - full flush (fence.i): clears every line, one index per cycle.
//   - single-line invalidate: clears one index.

---
 rtl/sargantana_icache_pkg.sv | 12 +
 rtl/sargantana_icache_line_counter.sv | 26 ++
 rtl/sargantana_icache_flush_ctrl.sv | 102 ++++++++++
 tb/tb_sargantana_icache_flush_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sargantana_icache_pkg.sv
// sargantana_icache_pkg: shared icache geometry and flush-controller state/mode types.
package sargantana_icache_pkg;

    localparam int ICACHE_DEPTH     = 256;
    localparam int ICACHE_IDX_WIDTH = $clog2(ICACHE_DEPTH);

    typedef enum logic [2:0] {IDLE, DRAIN, FLUSH, LINE, DONE} flush_state_t;

    // MODE_NONE marks the reset sweep, which completes without acknowledging anyone.
    typedef enum logic [1:0] {MODE_NONE, MODE_FULL, MODE_LINE} flush_mode_t;

endpackage

// File: rtl/sargantana_icache_line_counter.sv
// sargantana_icache_line_counter: sweep index counter; clears itself after the last line.
module sargantana_icache_line_counter #(
    parameter int DEPTH = sargantana_icache_pkg::ICACHE_DEPTH,
    parameter int W     = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         last
);
    import sargantana_icache_pkg::*;

    assign last = (cnt == W'(DEPTH - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt <= '0;
        else if (clr || (en && last))
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/sargantana_icache_flush_ctrl.sv
// sargantana_icache_flush_ctrl: sequences full-flush and single-line invalidation of the icache valid array.
// Define SARGANTANA_ICACHE_FLUSH_ON_RESET_EN to sweep the whole array straight out of reset.
module sargantana_icache_flush_ctrl #(
    parameter int ICACHE_DEPTH = sargantana_icache_pkg::ICACHE_DEPTH,
    parameter int IDX_WIDTH    = $clog2(ICACHE_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_req_i,
    output logic                 flush_ack_o,
    input  logic                 inv_req_i,
    input  logic [IDX_WIDTH-1:0] inv_idx_i,
    output logic                 inv_ack_o,
    input  logic                 refill_busy_i,
    output logic                 fetch_stall_o,
    output logic                 busy_o,
    output logic                 vld_we_o,
    output logic [IDX_WIDTH-1:0] vld_idx_o
);
    import sargantana_icache_pkg::*;

    if (ICACHE_DEPTH < 2 || (ICACHE_DEPTH & (ICACHE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ICACHE_DEPTH must be a power of two >= 2");
    end

`ifdef SARGANTANA_ICACHE_FLUSH_ON_RESET_EN
    localparam flush_state_t RST_STATE = FLUSH;
`else
    localparam flush_state_t RST_STATE = IDLE;
`endif

    flush_state_t         state_q, state_d;
    flush_mode_t          mode_q, mode_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d, cnt;
    logic                 pend_q, pend_d, last;

    sargantana_icache_line_counter #(
        .DEPTH (ICACHE_DEPTH),
        .W     (IDX_WIDTH)
    ) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (state_q == FLUSH),
        .clr   (state_q == IDLE),
        .cnt   (cnt),
        .last  (last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RST_STATE;
            mode_q  <= MODE_NONE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        // A line invalidate raised during a full flush is covered by the sweep itself.
        if ((state_q == DRAIN || state_q == FLUSH) && mode_q == MODE_FULL && inv_req_i)
            pend_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (flush_req_i) begin
                    state_d = DRAIN;
                    mode_d  = MODE_FULL;
                    pend_d  = inv_req_i;
                end else if (inv_req_i) begin
                    state_d = DRAIN;
                    mode_d  = MODE_LINE;
                    idx_d   = inv_idx_i;
                end
            end
            DRAIN:   state_d = refill_busy_i ? DRAIN : (mode_q == MODE_LINE ? LINE : FLUSH);
            FLUSH:   state_d = last ? DONE : FLUSH;
            LINE:    state_d = DONE;
            DONE: begin
                state_d = IDLE;
                mode_d  = MODE_NONE;
                pend_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o        = (state_q != IDLE);
    assign fetch_stall_o = busy_o;
    assign vld_we_o      = (state_q == FLUSH) || (state_q == LINE);
    assign vld_idx_o     = (state_q == FLUSH) ? cnt : (state_q == LINE) ? idx_q : '0;
    assign flush_ack_o   = (state_q == DONE) && (mode_q == MODE_FULL);
    assign inv_ack_o     = (state_q == DONE) && (mode_q == MODE_LINE || pend_q);

endmodule

// File: tb/tb_sargantana_icache_flush_ctrl.sv
// tb_sargantana_icache_flush_ctrl: directed checks of the flush controller at ICACHE_DEPTH=8.
module tb_sargantana_icache_flush_ctrl;

    localparam int DEPTH = 8;
    localparam int W     = 3;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         flush_req_i = 1'b0;
    logic         inv_req_i = 1'b0;
    logic [W-1:0] inv_idx_i = '0;
    logic         refill_busy_i = 1'b0;
    logic         flush_ack_o, inv_ack_o, fetch_stall_o, busy_o, vld_we_o;
    logic [W-1:0] vld_idx_o;

    int n_chk  = 0;
    int n_fail = 0;

    sargantana_icache_flush_ctrl #(
        .ICACHE_DEPTH (DEPTH),
        .IDX_WIDTH    (W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_req_i   (flush_req_i),
        .flush_ack_o   (flush_ack_o),
        .inv_req_i     (inv_req_i),
        .inv_idx_i     (inv_idx_i),
        .inv_ack_o     (inv_ack_o),
        .refill_busy_i (refill_busy_i),
        .fetch_stall_o (fetch_stall_o),
        .busy_o        (busy_o),
        .vld_we_o      (vld_we_o),
        .vld_idx_o     (vld_idx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic stall, input logic we,
                           input logic [W-1:0] idx, input logic fack, input logic iack);
        chk({tag, ".stall"}, {31'b0, fetch_stall_o}, {31'b0, stall});
        chk({tag, ".busy"},  {31'b0, busy_o},        {31'b0, stall});
        chk({tag, ".we"},    {31'b0, vld_we_o},      {31'b0, we});
        chk({tag, ".idx"},   {29'b0, vld_idx_o},     {29'b0, idx});
        chk({tag, ".fack"},  {31'b0, flush_ack_o},   {31'b0, fack});
        chk({tag, ".iack"},  {31'b0, inv_ack_o},     {31'b0, iack});
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic after_reset(input string tag);
`ifdef SARGANTANA_ICACHE_FLUSH_ON_RESET_EN
        for (int i = 0; i < DEPTH; i++) begin
            chk_out($sformatf("%s.boot%0d", tag, i), 1'b1, 1'b1, W'(i), 1'b0, 1'b0);
            step();
        end
        chk_out({tag, ".boot_done"}, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        step();
        chk_out({tag, ".boot_idle"}, 1'b0, 1'b0, '0, 1'b0, 1'b0);
`else
        chk_out({tag, ".idle"}, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        repeat (3) begin
            step();
            chk_out({tag, ".quiet"}, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
`endif
    endtask

    task automatic full_flush(input string tag);
        flush_req_i = 1'b1;
        step();
        chk_out({tag, ".c1"}, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk_out($sformatf("%s.w%0d", tag, i), 1'b1, 1'b1, W'(i), 1'b0, 1'b0);
        end
        step();
        chk_out({tag, ".ack"}, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        flush_req_i = 1'b0;
        step();
        chk_out({tag, ".idle"}, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #1 rst_i = 1'b1;
        #1;
`ifdef SARGANTANA_ICACHE_FLUSH_ON_RESET_EN
        chk_out("rst", 1'b1, 1'b1, '0, 1'b0, 1'b0);
`else
        chk_out("rst", 1'b0, 1'b0, '0, 1'b0, 1'b0);
`endif
        @(negedge clk_i);
        rst_i = 1'b0;
        after_reset("rel");

        full_flush("t1");

        inv_req_i = 1'b1;
        inv_idx_i = 3'd5;
        step();
        chk_out("t2.c1", 1'b1, 1'b0, '0, 1'b0, 1'b0);
        inv_idx_i = 3'd3;
        step();
        chk_out("t2.c2", 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
        step();
        chk_out("t2.c3", 1'b1, 1'b0, '0, 1'b0, 1'b1);
        inv_req_i = 1'b0;
        step();
        chk_out("t2.idle", 1'b0, 1'b0, '0, 1'b0, 1'b0);

        inv_req_i     = 1'b1;
        inv_idx_i     = 3'd2;
        refill_busy_i = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk_out($sformatf("t3.drain%0d", c), 1'b1, 1'b0, '0, 1'b0, 1'b0);
        end
        refill_busy_i = 1'b0;
        step();
        chk_out("t3.write", 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
        step();
        chk_out("t3.ack", 1'b1, 1'b0, '0, 1'b0, 1'b1);
        inv_req_i = 1'b0;
        step();
        chk_out("t3.idle", 1'b0, 1'b0, '0, 1'b0, 1'b0);

        flush_req_i = 1'b1;
        inv_req_i   = 1'b1;
        inv_idx_i   = 3'd6;
        step();
        chk_out("t4.c1", 1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk_out($sformatf("t4.w%0d", i), 1'b1, 1'b1, W'(i), 1'b0, 1'b0);
        end
        step();
        chk_out("t4.ack", 1'b1, 1'b0, '0, 1'b1, 1'b1);
        flush_req_i = 1'b0;
        inv_req_i   = 1'b0;
        step();
        chk_out("t4.idle", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        step();
        chk_out("t4.quiet", 1'b0, 1'b0, '0, 1'b0, 1'b0);

        flush_req_i = 1'b1;
        step();
        chk_out("t5.c1", 1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out($sformatf("t5.w%0d", i), 1'b1, 1'b1, W'(i), 1'b0, 1'b0);
        end
        rst_i       = 1'b1;
        flush_req_i = 1'b0;
        #1;
`ifdef SARGANTANA_ICACHE_FLUSH_ON_RESET_EN
        chk_out("t5.rst", 1'b1, 1'b1, '0, 1'b0, 1'b0);
`else
        chk_out("t5.rst", 1'b0, 1'b0, '0, 1'b0, 1'b0);
`endif
        @(negedge clk_i);
        rst_i = 1'b0;
        after_reset("t5.rel");
        full_flush("t5.reissue");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
